// File: rtl/pacman_mover.sv
// pacman_mover
//   Game-clock Pac-Man motion controller. Keeps the current tile and a sub-tile
//   pixel offset along the facing direction, and latches the latest joystick
//   request. Turns are taken only at tile centres, walls stop motion, and the
//   side tunnel wraps the x tile. Runs the life cycle alive -> dying -> dead.
//
// Ports
//   clk, rst          game-logic clock, synchronous active-high reset
//   tick              one-cycle game-step enable; all motion decisions use it
//   req_valid/req_dir joystick request (0 right, 1 up, 2 left, 3 down)
//   blocked[3:0]      blocked[d]=1 when the neighbour tile in direction d is closed
//   kill              ghost collision pulse (acts in IDLE/MOVE only)
//   restart           life/level restart pulse (acts in any state)
//   xtile, ytile      current tile to the maze logic
//   xloc, yloc        sprite centre pixel (combinational from registered state)
//   dir, animation    facing direction and mouth/death frame
//   alive, moving     state flags
//   tile_step         one-cycle pulse when the tile changes through movement
//   death_done        one-cycle pulse on the DYING -> DEAD transition
module pacman_mover #(
    parameter int TILE_PX     = 8,
    parameter int MAZE_W      = 28,
    parameter int MAZE_H      = 36,
    parameter int Y_OFS_TILES = 3,
    parameter int START_XTILE = 15,
    parameter int START_YTILE = 25,
    parameter int ANIM_DIV    = 4,
    parameter int DEATH_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_valid,
    input  logic [1:0] req_dir,
    input  logic [3:0] blocked,
    input  logic       kill,
    input  logic       restart,
    output logic [6:0] xtile,
    output logic [6:0] ytile,
    output logic [9:0] xloc,
    output logic [9:0] yloc,
    output logic [1:0] dir,
    output logic [1:0] animation,
    output logic       alive,
    output logic       moving,
    output logic       tile_step,
    output logic       death_done
);

    localparam int OFS_W = $clog2(TILE_PX);
    localparam int AD_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int DC_W  = $clog2(DEATH_TICKS);
    localparam int DA_W  = DC_W + 2;

    localparam logic [OFS_W-1:0] OFS_MAX  = OFS_W'(TILE_PX - 1);
    localparam logic [9:0]       HALF_PX  = 10'(TILE_PX / 2 - 1);
    localparam logic [AD_W-1:0]  AD_LAST  = AD_W'(ANIM_DIV - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEATH_TICKS - 1);
    localparam logic [DA_W-1:0]  DEATH_Q1 = DA_W'(DEATH_TICKS);
    localparam logic [DA_W-1:0]  DEATH_Q2 = DA_W'(2 * DEATH_TICKS);
    localparam logic [DA_W-1:0]  DEATH_Q3 = DA_W'(3 * DEATH_TICKS);

    typedef enum logic [1:0] {IDLE, MOVE, DYING, DEAD} state_t;

    state_t           state_reg;
    logic [6:0]       xtile_reg, ytile_reg;
    logic [OFS_W-1:0] off_reg;
    logic [1:0]       dir_reg, pending_reg, anim_reg;
    logic [AD_W-1:0]  anim_div_reg;
    logic [DC_W-1:0]  death_cnt_reg;
    logic             tile_step_reg, death_done_reg;

    logic [1:0]       pend_next;
    logic [6:0]       xtile_next, ytile_next;
    logic [DC_W-1:0]  death_cnt_next;
    logic [DA_W-1:0]  death_cnt_x4;
    logic [1:0]       death_anim_next;
    logic [9:0]       x_base, y_base, off_ext;

    // A request arriving on a tick cycle is already the one acted upon.
    assign pend_next = req_valid ? req_dir : pending_reg;

    // Neighbour tile in the current facing direction; x wraps through the tunnel.
    always_comb begin
        xtile_next = xtile_reg;
        ytile_next = ytile_reg;
        case (dir_reg)
            2'd0: xtile_next = (xtile_reg == 7'(MAZE_W - 1)) ? 7'd0 : xtile_reg + 7'd1;
            2'd1: ytile_next = (ytile_reg == 7'd0) ? ytile_reg : ytile_reg - 7'd1;
            2'd2: xtile_next = (xtile_reg == 7'd0) ? 7'(MAZE_W - 1) : xtile_reg - 7'd1;
            default: ytile_next = (ytile_reg == 7'(MAZE_H - 1)) ? ytile_reg : ytile_reg + 7'd1;
        endcase
    end

    // Death frame = min(3, cnt*4/DEATH_TICKS), done with compares instead of a divider.
    assign death_cnt_next = death_cnt_reg + DC_W'(1);
    assign death_cnt_x4   = {death_cnt_next, 2'b00};
    always_comb begin
        if (death_cnt_x4 >= DEATH_Q3)      death_anim_next = 2'd3;
        else if (death_cnt_x4 >= DEATH_Q2) death_anim_next = 2'd2;
        else if (death_cnt_x4 >= DEATH_Q1) death_anim_next = 2'd1;
        else                               death_anim_next = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state_reg      <= IDLE;
            xtile_reg      <= 7'(START_XTILE);
            ytile_reg      <= 7'(START_YTILE);
            off_reg        <= '0;
            dir_reg        <= 2'd2;
            pending_reg    <= 2'd2;
            anim_reg       <= 2'd0;
            anim_div_reg   <= '0;
            death_cnt_reg  <= '0;
            tile_step_reg  <= 1'b0;
            death_done_reg <= 1'b0;
        end else begin
            tile_step_reg  <= 1'b0;
            death_done_reg <= 1'b0;
            if (req_valid) pending_reg <= req_dir;

            case (state_reg)
                IDLE, MOVE: begin
                    if (kill) begin
                        state_reg     <= DYING;
                        death_cnt_reg <= '0;
                        anim_reg      <= 2'd0;
                    end else if (tick && state_reg == IDLE) begin
                        if (!blocked[pend_next]) begin
                            dir_reg      <= pend_next;
                            off_reg      <= OFS_W'(1);
                            anim_div_reg <= '0;
                            state_reg    <= MOVE;
                        end
                    end else if (tick) begin
                        if (anim_div_reg == AD_LAST) begin
                            anim_div_reg <= '0;
                            anim_reg     <= anim_reg + 2'd1;
                        end else begin
                            anim_div_reg <= anim_div_reg + AD_W'(1);
                        end

                        if (off_reg != '0) begin
                            if (pend_next == (dir_reg ^ 2'b10)) begin
                                // Re-express the same pixel from the tile we were heading to.
                                dir_reg       <= pend_next;
                                xtile_reg     <= xtile_next;
                                ytile_reg     <= ytile_next;
                                off_reg       <= OFS_W'(TILE_PX - int'(off_reg));
                                tile_step_reg <= 1'b1;
                            end else if (off_reg == OFS_MAX) begin
                                off_reg       <= '0;
                                xtile_reg     <= xtile_next;
                                ytile_reg     <= ytile_next;
                                tile_step_reg <= 1'b1;
                            end else begin
                                off_reg <= off_reg + OFS_W'(1);
                            end
                        end else if (!blocked[pend_next]) begin
                            dir_reg <= pend_next;
                            off_reg <= OFS_W'(1);
                        end else if (!blocked[dir_reg]) begin
                            off_reg <= OFS_W'(1);
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                DYING: begin
                    if (tick) begin
                        if (death_cnt_reg == DC_LAST) begin
                            state_reg      <= DEAD;
                            death_done_reg <= 1'b1;
                        end else begin
                            death_cnt_reg <= death_cnt_next;
                            anim_reg      <= death_anim_next;
                        end
                    end
                end
                default: ; // DEAD: frozen until restart/rst
            endcase
        end
    end

    // Pixel position: tile centre shifted by the offset along the facing axis.
    assign off_ext = {{(10 - OFS_W){1'b0}}, off_reg};
    assign x_base  = ({3'b000, xtile_reg} << OFS_W) + HALF_PX;
    assign y_base  = (({3'b000, ytile_reg} + 10'(Y_OFS_TILES)) << OFS_W) + HALF_PX;

    always_comb begin
        xloc = x_base;
        yloc = y_base;
        case (dir_reg)
            2'd0: xloc = x_base + off_ext;
            2'd1: yloc = y_base - off_ext;
            2'd2: xloc = x_base - off_ext;
            default: yloc = y_base + off_ext;
        endcase
    end

    assign xtile      = xtile_reg;
    assign ytile      = ytile_reg;
    assign dir        = dir_reg;
    assign animation  = anim_reg;
    assign alive      = (state_reg == IDLE) || (state_reg == MOVE);
    assign moving     = (state_reg == MOVE);
    assign tile_step  = tile_step_reg;
    assign death_done = death_done_reg;

endmodule
